seq_scan_ctrl: RTL

Byte-stream front end and sequencer for the serial pattern detector. Accepts bytes over a valid/ready handshake and serializes them MSB-first into a programmable pattern-match core, one bit per clock. It also counts matches and raises a sticky threshold interrupt. It sits between a byte source (UART RX / DMA) and the host register block, and owns detector configuration.

---
 rtl/seq_scan_pkg.sv | 29 ++
 rtl/pattern_match_core.sv | 76 +++++++
 rtl/seq_scan_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial pattern scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_scan_pkg;

   // Handshake / serializer state
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Detector configuration loaded by reset
   localparam logic [3:0] DEF_PATTERN = 4'b1011;
   localparam int         DEF_LEN     = 4;

   // Map a programmed length onto the range the core can compare:
   // zero means a single-bit pattern, anything longer than the
   // history register is truncated to the history length.
   function automatic int clamp_len(input int len, input int max_len);
      if (len == 0) begin
         return 1;
      end else if (len > max_len) begin
         return max_len;
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Bit-serial pattern matcher: shifts one bit per valid cycle into a history register.
// Latency: match_o is registered, one cycle after the completing bit; hit_o is its combinational next value.
// Backpressure: none; consumes a bit on every cycle bit_vld_i is high.
//
// Ports: clk_i/reset_i (sync, active high), bit_in_i/bit_vld_i (serial input),
//        pattern_i/eff_len_i (already-clamped length), clear_i (drop history),
//        match_o (registered pulse), hit_o (same-cycle hit for the counter).
// Build option: SEQ_SCAN_OVERLAP_EN keeps history after a hit (overlapping matches).
module pattern_match_core
   import seq_scan_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int LEN_W = 3
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             bit_in_i,
   input  logic             bit_vld_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [LEN_W-1:0] eff_len_i,
   input  logic             clear_i,
   output logic             match_o,
   output logic             hit_o
);

   logic [PAT_W-1:0] history_q;
   logic [LEN_W-1:0] fill_q;
   logic             match_q;

   logic [PAT_W-1:0] hist_shift;
   logic [LEN_W-1:0] fill_inc;
   logic [PAT_W-1:0] mask;
   logic             hit;

   always_comb begin
      // Newest bit enters at bit 0
      hist_shift = {history_q[PAT_W-2:0], bit_in_i};
      // Fill saturates at the history length; beyond that it carries no information
      fill_inc   = (fill_q >= LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
      mask       = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < int'(eff_len_i));
      end
      hit = bit_vld_i && !clear_i && (fill_inc >= eff_len_i) &&
            ((hist_shift & mask) == (pattern_i & mask));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         history_q <= '0;
         fill_q    <= '0;
         match_q   <= 1'b0;
      end else begin
         match_q <= hit;
         if (bit_vld_i) begin
`ifdef SEQ_SCAN_OVERLAP_EN
            history_q <= hist_shift;
            fill_q    <= fill_inc;
`else
            // Non-overlapping: the next hit must be built from fresh bits
            if (hit) begin
               history_q <= '0;
               fill_q    <= '0;
            end else begin
               history_q <= hist_shift;
               fill_q    <= fill_inc;
            end
`endif
         end
      end
   end

   assign match_o = match_q;
   assign hit_o   = hit;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Byte-stream front end: serializes bytes MSB-first into the pattern core, counts hits, raises sticky irq.
// Latency: bit 7 reaches the core the cycle after the handshake; match/count/irq one cycle after each bit.
// Backpressure: in_ready_o only in IDLE or on the last bit of a byte; 8 cycles/byte back-to-back.
//
// Ports: clk_i, reset_i (sync, active high);
//        cfg_we_i/cfg_pattern_i/cfg_len_i/cfg_thresh_i (honoured only while idle);
//        in_valid_i/in_data_i/in_ready_o (byte handshake); busy_o (serializing);
//        match_o (hit pulse), match_cnt_o (saturating count), irq_o/irq_clr_i (sticky threshold irq).
// Build option: SEQ_SCAN_OVERLAP_EN selects overlapping detection in the core.
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int LEN_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             cfg_we_i,
   input  logic [PAT_W-1:0] cfg_pattern_i,
   input  logic [LEN_W-1:0] cfg_len_i,
   input  logic [CNT_W-1:0] cfg_thresh_i,
   input  logic             in_valid_i,
   input  logic [7:0]       in_data_i,
   output logic             in_ready_o,
   output logic             busy_o,
   output logic             match_o,
   output logic [CNT_W-1:0] match_cnt_o,
   output logic             irq_o,
   input  logic             irq_clr_i
);

   state_e           state_q;
   logic [7:0]       data_q;
   logic [2:0]       bit_idx_q;
   logic             ready_q;
   logic             busy_q;

   logic [PAT_W-1:0] pattern_q;
   logic [LEN_W-1:0] len_q;
   logic [CNT_W-1:0] thresh_q;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             irq_q, irq_d;
   logic             irq_set;

   logic             cfg_load;
   logic             core_hit;
   logic [LEN_W-1:0] eff_len;

   assign cfg_load = cfg_we_i && (state_q == IDLE);
   assign eff_len  = LEN_W'(clamp_len(int'(len_q), PAT_W));

   // Handshake FSM; ready_q mirrors "IDLE or last bit" one cycle ahead
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         data_q    <= '0;
         bit_idx_q <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  data_q    <= in_data_i;
                  bit_idx_q <= 3'd7;
                  state_q   <= SHIFT;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            SHIFT: begin
               if (bit_idx_q == 3'd0) begin
                  if (in_valid_i) begin
                     data_q    <= in_data_i;
                     bit_idx_q <= 3'd7;
                     ready_q   <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  bit_idx_q <= bit_idx_q - 3'd1;
                  ready_q   <= (bit_idx_q == 3'd1);
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pattern_q <= PAT_W'(DEF_PATTERN);
         len_q     <= LEN_W'(DEF_LEN);
         thresh_q  <= '0;
      end else if (cfg_load) begin
         pattern_q <= cfg_pattern_i;
         len_q     <= cfg_len_i;
         thresh_q  <= cfg_thresh_i;
      end
   end

   pattern_match_core #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_core (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .bit_in_i  (data_q[bit_idx_q]),
      .bit_vld_i (state_q == SHIFT),
      .pattern_i (pattern_q),
      .eff_len_i (eff_len),
      .clear_i   (cfg_load),
      .match_o   (match_o),
      .hit_o     (core_hit)
   );

   always_comb begin
      cnt_d   = cnt_q;
      irq_d   = irq_q;
      irq_set = 1'b0;
      if (cfg_load) begin
         cnt_d = '0;
         irq_d = 1'b0;
      end else begin
         if (core_hit) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
         end
         // Every hit at or past a nonzero threshold asserts set, so a clear
         // landing on the same cycle as such a hit cannot drop the irq.
         irq_set = core_hit && (thresh_q != '0) && (cnt_d >= thresh_q);
         if (irq_set) begin
            irq_d = 1'b1;
         end else if (irq_clr_i) begin
            irq_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         irq_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         irq_q <= irq_d;
      end
   end

   assign in_ready_o  = ready_q && !reset_i;
   assign busy_o      = busy_q;
   assign match_cnt_o = cnt_q;
   assign irq_o       = irq_q;

endmodule
